// File: rtl/conv_load_sequencer_if.sv
// rtl/conv_load_sequencer_if.sv - packet handshake from the load sequencer toward the NoC injection port
interface conv_load_sequencer_if;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [29:0] pkt_data;

  modport master (output pkt_valid, output pkt_data, input pkt_ready);
  modport slave  (input pkt_valid, input pkt_data, output pkt_ready);
endinterface

// File: rtl/conv_load_sequencer.sv
// rtl/conv_load_sequencer.sv - streams filter weights then per-row ifmap packets to the PE array
module conv_load_sequencer #(
  parameter int FILTER_SIZE  = 5,
  parameter int IFMAP_SIZE   = 25,
  parameter int NUM_PE       = 5,
  parameter int PE_ADDR_BASE = 0
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         start,
  output logic                                         busy,
  output logic                                         done,
  output logic                                         proto_err,
  output logic [$clog2(FILTER_SIZE*FILTER_SIZE)-1:0]   w_addr,
  input  logic [7:0]                                   w_data,
  output logic [$clog2(IFMAP_SIZE)-1:0]                if_addr,
  input  logic [IFMAP_SIZE-1:0]                        if_data,
  input  logic                                         row_done,
  output logic [$clog2(IFMAP_SIZE-FILTER_SIZE+1)-1:0]  cur_row,
  conv_load_sequencer_if.master                        pkt
);

  localparam int OUTPUT_DIM = IFMAP_SIZE - FILTER_SIZE + 1;
  localparam int WA_W       = $clog2(FILTER_SIZE*FILTER_SIZE);
  localparam int IA_W       = $clog2(IFMAP_SIZE);
  localparam int ROW_W      = $clog2(OUTPUT_DIM);
  localparam int PE_W       = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int K_W        = $clog2(FILTER_SIZE + 2);

  typedef enum logic [2:0] {
    IDLE, W_RD0, W_RD1, W_PKT, I_RD, I_PKT, ROW_WAIT, DONE
  } state_t;

  state_t           state, state_nxt;
  logic [PE_W-1:0]  pe, pe_nxt;
  logic [K_W-1:0]   k, k_nxt;
  logic [ROW_W-1:0] row, row_nxt;
  logic [7:0]       w_lo, w_lo_nxt;
  logic [7:0]       w_hi;
  logic [24:0]      in_field;
  logic [3:0]       dest;
  logic             pkt_valid_q;
  logic             proto_err_q;
  logic             hs;

  assign hs            = pkt_valid_q && pkt.pkt_ready;
  assign pkt.pkt_valid = pkt_valid_q;
  assign proto_err     = proto_err_q;
  assign cur_row       = row;
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pe          <= '0;
      k           <= '0;
      row         <= '0;
      w_lo        <= '0;
      pkt_valid_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      pe          <= pe_nxt;
      k           <= k_nxt;
      row         <= row_nxt;
      w_lo        <= w_lo_nxt;
      pkt_valid_q <= (state_nxt == W_PKT) || (state_nxt == I_PKT);
      // A misplaced row_done in the same cycle as start still counts as an error
      if (row_done && state != ROW_WAIT)
        proto_err_q <= 1'b1;
      else if (state == IDLE && start)
        proto_err_q <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    pe_nxt    = pe;
    k_nxt     = k;
    row_nxt   = row;
    w_lo_nxt  = w_lo;
    case (state)
      IDLE: begin
        if (start) begin
          pe_nxt    = '0;
          k_nxt     = '0;
          row_nxt   = '0;
          state_nxt = W_RD0;
        end
      end
      W_RD0: state_nxt = W_RD1;
      W_RD1: begin
        w_lo_nxt  = w_data;
        state_nxt = W_PKT;
      end
      W_PKT: begin
        if (hs) begin
          if (int'(k) + 2 >= FILTER_SIZE) begin
            k_nxt = '0;
            if (int'(pe) == NUM_PE - 1) begin
              pe_nxt    = '0;
              state_nxt = I_RD;
            end else begin
              pe_nxt    = pe + PE_W'(1);
              state_nxt = W_RD0;
            end
          end else begin
            k_nxt     = K_W'(int'(k) + 2);
            state_nxt = W_RD0;
          end
        end
      end
      I_RD: state_nxt = I_PKT;
      I_PKT: begin
        if (hs) begin
          if (int'(pe) == NUM_PE - 1) begin
            pe_nxt    = '0;
            state_nxt = ROW_WAIT;
          end else begin
            pe_nxt    = pe + PE_W'(1);
            state_nxt = I_RD;
          end
        end
      end
      ROW_WAIT: begin
        if (row_done) begin
          if (int'(row) == OUTPUT_DIM - 1) begin
            state_nxt = DONE;
          end else begin
            row_nxt   = row + ROW_W'(1);
            state_nxt = I_RD;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Addresses are held through the packet states so the synchronous memories
  // keep presenting the same word while the NoC stalls.
  always_comb begin
    w_addr       = '0;
    if_addr      = '0;
    pkt.pkt_data = '0;
    w_hi         = (int'(k) + 1 >= FILTER_SIZE) ? 8'h00 : w_data;
    in_field     = '0;
    in_field[IFMAP_SIZE-1:0] = if_data;
    dest         = 4'(PE_ADDR_BASE + int'(pe));
    case (state)
      W_RD0: w_addr = WA_W'(int'(pe) * FILTER_SIZE + int'(k));
      W_RD1: w_addr = WA_W'(int'(pe) * FILTER_SIZE + int'(k) + 1);
      W_PKT: begin
        w_addr       = WA_W'(int'(pe) * FILTER_SIZE + int'(k) + 1);
        pkt.pkt_data = {dest, 1'b0, 9'h000, w_hi, w_lo};
      end
      I_RD:  if_addr = IA_W'(int'(row) + int'(pe));
      I_PKT: begin
        if_addr      = IA_W'(int'(row) + int'(pe));
        pkt.pkt_data = {dest, 1'b1, in_field};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_conv_load_sequencer.sv
// tb/tb_conv_load_sequencer.sv - scoreboard bench for conv_load_sequencer
module tb_conv_load_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        done;
  logic        proto_err;
  logic [4:0]  w_addr;
  logic [7:0]  w_data;
  logic [4:0]  if_addr;
  logic [24:0] if_data;
  logic        row_done;
  logic [4:0]  cur_row;

  conv_load_sequencer_if pkt_if ();

  conv_load_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .proto_err (proto_err),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .if_addr   (if_addr),
    .if_data   (if_data),
    .row_done  (row_done),
    .cur_row   (cur_row),
    .pkt       (pkt_if)
  );

  always #5 clk = ~clk;

  logic [7:0]  rom [0:31];
  logic [24:0] ifm [0:31];

  always @(posedge clk) begin
    w_data  <= rom[w_addr];
    if_data <= ifm[if_addr];
  end

  typedef struct packed {
    logic [29:0] pkt;
    logic [4:0]  row;
  } exp_t;

  exp_t sbq [$];
  int   n_asserts = 0;
  int   n_fails   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_model();
    exp_t e;
    logic [7:0] lo, hi;
    for (int p = 0; p < 5; p++) begin
      for (int kk = 0; kk < 5; kk += 2) begin
        lo = rom[p*5 + kk];
        hi = (kk + 1 < 5) ? rom[p*5 + kk + 1] : 8'h00;
        e.pkt = {4'(p), 1'b0, 9'h000, hi, lo};
        e.row = 5'd0;
        sbq.push_back(e);
      end
    end
    for (int r = 0; r < 21; r++) begin
      for (int p = 0; p < 5; p++) begin
        e.pkt = {4'(p), 1'b1, ifm[r + p]};
        e.row = 5'(r);
        sbq.push_back(e);
      end
    end
  endtask

  task automatic run_conv(input bit stall, input bit err_pulse, input bit busy_start, input int abort_row);
    int          cd, n_in, n_done, first_valid, first_in;
    bit          was_stalled, aborted;
    logic [29:0] held;
    exp_t        e;
    cd = 0; n_in = 0; n_done = 0; first_valid = -1; first_in = -1;
    was_stalled = 0; aborted = 0; held = '0;
    push_model();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("err_clr", 32'(proto_err), 32'(1'b0));
    for (int cyc = 0; cyc < 4000 && n_done == 0 && !aborted; cyc++) begin
      if (done) n_done++;
      if (was_stalled && pkt_if.pkt_valid)
        check("stall_stable", 32'(pkt_if.pkt_data), 32'(held));
      row_done = 1'b0;
      start    = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) row_done = 1'b1;
        if (busy_start && cd == 1 && n_in == 5) start = 1'b1;
      end
      if (err_pulse && cyc == 10) row_done = 1'b1;
      pkt_if.pkt_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pkt_if.pkt_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (pkt_if.pkt_ready) begin
          was_stalled = 0;
          if (sbq.size() == 0) begin
            check("sb_underflow", 32'(sbq.size()), 32'd1);
          end else begin
            e = sbq.pop_front();
            check("pkt_data", 32'(pkt_if.pkt_data), 32'(e.pkt));
            check("cur_row", 32'(cur_row), 32'(e.row));
          end
          if (pkt_if.pkt_data[25]) begin
            if (first_in < 0) first_in = cyc;
            n_in++;
            if (n_in % 5 == 0) cd = 3;
          end
        end else begin
          was_stalled = 1;
          held        = pkt_if.pkt_data;
        end
      end else begin
        was_stalled = 0;
      end
      if (abort_row >= 0 && n_in == abort_row*5 + 2) begin
        rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(pkt_if.pkt_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_row", 32'(cur_row), 32'd0);
        aborted = 1;
      end
      @(negedge clk);
    end
    row_done = 1'b0;
    pkt_if.pkt_ready = 1'b1;
    if (aborted) begin
      @(negedge clk);
      rst_n = 1'b1;
      sbq.delete();
    end else begin
      for (int i = 0; i < 10; i++) begin
        if (done) n_done++;
        @(negedge clk);
      end
      check("done_count", 32'(n_done), 32'd1);
      check("sb_empty", 32'(sbq.size()), 32'd0);
      check("busy_after", 32'(busy), 32'd0);
      check("proto_err_end", 32'(proto_err), 32'(err_pulse));
      if (!stall) begin
        check("first_pkt_cycle", 32'(first_valid), 32'd2);
        check("first_in_cycle", 32'(first_in), 32'd46);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      rom[i] = (i < 25) ? 8'(i - 12) : 8'h00;
      ifm[i] = (i < 25) ? (25'h1 << i) : 25'h0;
    end
    rst_n            = 1'b0;
    start            = 1'b0;
    row_done         = 1'b0;
    pkt_if.pkt_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(pkt_if.pkt_valid), 32'd0);
    check("rst_err", 32'(proto_err), 32'd0);
    check("rst_data", 32'(pkt_if.pkt_data), 32'd0);
    check("rst_waddr", 32'(w_addr), 32'd0);
    check("rst_ifaddr", 32'(if_addr), 32'd0);
    check("rst_row", 32'(cur_row), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_conv(1'b0, 1'b0, 1'b0, -1);
    run_conv(1'b1, 1'b1, 1'b0, -1);
    run_conv(1'b0, 1'b0, 1'b1, -1);
    run_conv(1'b0, 1'b0, 1'b0, 7);
    run_conv(1'b0, 1'b0, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
